// File: rtl/spi_defs.sv
// Shared definitions for the mode-0 SPI master: FSM state encodings,
// SPI mode constants and default transfer geometry.
package spi_defs;

    // Sequencer states; encodings are fixed so they read the same in waveforms
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        TRAIL = 3'd4,
        FIN   = 3'd5
    } spi_state_t;

    // SPI mode 0: clock idles low, data sampled on the rising edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV   = 2;
    localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/spi_shift_reg.sv
// Generic shift register with parallel load and selectable direction.
// Left shift (lsb_first=0): serial_in enters the LSB, serial_out is the MSB.
// Right shift (lsb_first=1): serial_in enters the MSB, serial_out is the LSB.
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             lsb_first,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data,
    output logic             serial_out
);

    // Load has priority over shift so a new transfer always starts clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_en) begin
            if (lsb_first) begin
                data <= {serial_in, data[WIDTH-1:1]};
            end else begin
                data <= {data[WIDTH-2:0], serial_in};
            end
        end
    end

    assign serial_out = lsb_first ? data[0] : data[WIDTH-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master sequencer. Generates CS_N, SCLK and MOSI from a divided
// system clock and captures MISO on each rising SCLK edge.
// Optional feature macro: SPI_LSB_FIRST_EN adds the LSB_FIRST input, which
// selects LSB-first bit order per transfer; without it transfers are MSB-first.
module spi_master_ctrl
    import spi_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = DEFAULT_DIV,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             START,
    input  logic [WIDTH-1:0] TX_DATA,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO,
`ifdef SPI_LSB_FIRST_EN
    input  logic             LSB_FIRST,
`endif
    output logic             CS_N
);

    // bit_cnt must be able to reach WIDTH after the final bit
    localparam int BIT_W = $clog2(WIDTH + 1);

    spi_state_t       state;
    logic [CNT_W-1:0] half_cnt;
    logic [BIT_W-1:0] bit_cnt;

    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] rx_q;
    logic             tx_serial_unused;
    logic             rx_serial_unused;

    logic             accept;
    logic             half_last;
    logic             bit_last;
    logic             rx_shift;
    logic             tx_shift;
    logic             start_lsb;
    logic             lsb_sel;
    logic             start_bit;
    logic             next_bit;

`ifdef SPI_LSB_FIRST_EN
    // Bit order is latched with START so it stays fixed for the whole transfer
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            lsb_sel <= 1'b0;
        end else if (accept) begin
            lsb_sel <= LSB_FIRST;
        end
    end

    assign start_lsb = LSB_FIRST;
`else
    assign lsb_sel   = 1'b0;
    assign start_lsb = 1'b0;
`endif

    assign accept    = (state == IDLE) && START;
    assign half_last = (half_cnt == CNT_W'(DIV - 1));
    assign bit_last  = (bit_cnt == BIT_W'(WIDTH - 1));
    assign rx_shift  = (state == LOW) && half_last;
    assign tx_shift  = (state == HIGH) && half_last && !bit_last;

    // First bit comes straight from TX_DATA; later bits from the shifted word
    assign start_bit = start_lsb ? TX_DATA[0] : TX_DATA[WIDTH-1];
    assign next_bit  = lsb_sel ? tx_q[1] : tx_q[WIDTH-2];

    spi_shift_reg #(.WIDTH(WIDTH)) u_tx_sh (
        .clk        (CLK),
        .rst_n      (CLR_N),
        .load       (accept),
        .load_data  (TX_DATA),
        .shift_en   (tx_shift),
        .lsb_first  (lsb_sel),
        .serial_in  (1'b0),
        .data       (tx_q),
        .serial_out (tx_serial_unused)
    );

    spi_shift_reg #(.WIDTH(WIDTH)) u_rx_sh (
        .clk        (CLK),
        .rst_n      (CLR_N),
        .load       (accept),
        .load_data  ({WIDTH{1'b0}}),
        .shift_en   (rx_shift),
        .lsb_first  (lsb_sel),
        .serial_in  (MISO),
        .data       (rx_q),
        .serial_out (rx_serial_unused)
    );

    // Transfer sequencer: every state lasts DIV cycles except FIN, and all pins are registered
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state    <= IDLE;
            half_cnt <= '0;
            bit_cnt  <= '0;
            CS_N     <= 1'b1;
            SCLK     <= SPI_CPOL;
            MOSI     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            RX_DATA  <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state    <= LEAD;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                        CS_N     <= 1'b0;
                        BUSY     <= 1'b1;
                        MOSI     <= start_bit;
                    end
                end
                LEAD: begin
                    if (half_last) begin
                        state    <= LOW;
                        half_cnt <= '0;
                    end else begin
                        half_cnt <= half_cnt + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (half_last) begin
                        state    <= HIGH;
                        half_cnt <= '0;
                        SCLK     <= 1'b1;
                    end else begin
                        half_cnt <= half_cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (half_last) begin
                        half_cnt <= '0;
                        SCLK     <= 1'b0;
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                        if (bit_last) begin
                            state <= TRAIL;
                        end else begin
                            state <= LOW;
                            MOSI  <= next_bit;
                        end
                    end else begin
                        half_cnt <= half_cnt + CNT_W'(1);
                    end
                end
                TRAIL: begin
                    if (half_last) begin
                        state    <= FIN;
                        half_cnt <= '0;
                        CS_N     <= 1'b1;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                        RX_DATA  <= rx_q;
                        MOSI     <= 1'b0;
                    end else begin
                        half_cnt <= half_cnt + CNT_W'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    half_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed testbench for spi_master_ctrl. Instance dut_a runs DIV=2 with a
// selectable loopback/slave MISO source; dut_b runs DIV=1 in loopback.
// The LSB-first scenario is compiled only with SPI_LSB_FIRST_EN.
module tb_spi_master_ctrl;

    logic       clk;
    logic       clr_n;

    logic       a_start, a_busy, a_done, a_sclk, a_mosi, a_miso, a_cs_n;
    logic [7:0] a_tx, a_rx;
    logic       b_start, b_busy, b_done, b_sclk, b_mosi, b_miso, b_cs_n;
    logic [7:0] b_tx, b_rx;
`ifdef SPI_LSB_FIRST_EN
    logic       a_lsb, b_lsb;
`endif

    logic       loopback;
    logic [7:0] slave_word;
    logic       slave_bit;
    int         slave_idx;

    int         checks;
    int         failures;
    int         a_done_cnt;
    int         b_done_cnt;
    int         rise_cnt;
    logic [7:0] mosi_log;

    spi_master_ctrl #(.WIDTH(8), .DIV(2), .CNT_W(8)) dut_a (
        .CLK       (clk),
        .CLR_N     (clr_n),
        .START     (a_start),
        .TX_DATA   (a_tx),
        .RX_DATA   (a_rx),
        .BUSY      (a_busy),
        .DONE      (a_done),
        .SCLK      (a_sclk),
        .MOSI      (a_mosi),
        .MISO      (a_miso),
`ifdef SPI_LSB_FIRST_EN
        .LSB_FIRST (a_lsb),
`endif
        .CS_N      (a_cs_n)
    );

    spi_master_ctrl #(.WIDTH(8), .DIV(1), .CNT_W(8)) dut_b (
        .CLK       (clk),
        .CLR_N     (clr_n),
        .START     (b_start),
        .TX_DATA   (b_tx),
        .RX_DATA   (b_rx),
        .BUSY      (b_busy),
        .DONE      (b_done),
        .SCLK      (b_sclk),
        .MOSI      (b_mosi),
        .MISO      (b_miso),
`ifdef SPI_LSB_FIRST_EN
        .LSB_FIRST (b_lsb),
`endif
        .CS_N      (b_cs_n)
    );

    assign a_miso = loopback ? a_mosi : slave_bit;
    assign b_miso = b_mosi;

    // 100 MHz system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count DONE pulses away from the active edge
    always @(negedge clk) begin
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
    end

    // Record MOSI at every rising SCLK of dut_a
    always @(posedge a_sclk) begin
        rise_cnt++;
        mosi_log = {mosi_log[6:0], a_mosi};
    end

    // Slave model: present MSB when selected, advance on falling SCLK
    always @(negedge a_cs_n) begin
        slave_idx = 7;
        slave_bit = slave_word[7];
    end

    always @(negedge a_sclk) begin
        if (!a_cs_n && slave_idx > 0) begin
            slave_idx--;
            slave_bit = slave_word[slave_idx];
        end
    end

    // Runs one dut_a transfer; optionally pokes START with TX_DATA=0 at cycle poke_at
    task automatic run_a(input logic [7:0] tx, input int poke_at,
                         output int done_at, output int cs_low, output int busy_high);
        done_at   = -1;
        cs_low    = 0;
        busy_high = 0;
        rise_cnt  = 0;
        mosi_log  = '0;
        @(negedge clk);
        a_tx    = tx;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (!a_cs_n) cs_low++;
            if (a_busy) busy_high++;
            if (a_done) begin
                done_at = n;
                break;
            end
            a_start = (n == poke_at);
            if (n == poke_at) a_tx = 8'h00;
            @(negedge clk);
        end
        a_start = 1'b0;
    endtask

    task automatic test_reset();
        // Initial power-on reset values
        repeat (3) @(negedge clk);
        checks++; if (a_cs_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_cs_n: got %b want 1", a_cs_n); end
        checks++; if (a_sclk !== 1'b0) begin failures++; $display("[TB] FAIL reset_sclk: got %b want 0", a_sclk); end
        checks++; if (a_mosi !== 1'b0) begin failures++; $display("[TB] FAIL reset_mosi: got %b want 0", a_mosi); end
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_done: got %b%b want 00", a_busy, a_done); end
        checks++; if (a_rx !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx: got %h want 00", a_rx); end
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Abort a transfer with a 3-cycle reset
        loopback   = 1'b1;
        a_done_cnt = 0;
        a_tx       = 8'h5A;
        a_start    = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (a_cs_n !== 1'b0) begin failures++; $display("[TB] FAIL pre_abort_cs_n: got %b want 0", a_cs_n); end
        #2 clr_n = 1'b0;
        #1;
        checks++; if (a_cs_n !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("[TB] FAIL async_reset: cs_n/busy got %b%b want 10", a_cs_n, a_busy); end
        repeat (3) @(negedge clk);
        checks++; if (a_sclk !== 1'b0) begin failures++; $display("[TB] FAIL abort_sclk: got %b want 0", a_sclk); end
        checks++; if (a_rx !== 8'h00) begin failures++; $display("[TB] FAIL abort_rx: got %h want 00", a_rx); end
        clr_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if (a_done_cnt !== 0) begin failures++; $display("[TB] FAIL abort_no_done: got %0d pulses want 0", a_done_cnt); end
        checks++; if (a_cs_n !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_idle: cs_n/busy got %b%b want 10", a_cs_n, a_busy); end
    endtask

    task automatic test_loopback();
        int done_at, cs_low, busy_high;
        loopback = 1'b1;
        run_a(8'hA5, -10, done_at, cs_low, busy_high);
        checks++; if (done_at !== 37) begin failures++; $display("[TB] FAIL loop_done_cycle: got %0d want 37", done_at); end
        checks++; if (rise_cnt !== 8) begin failures++; $display("[TB] FAIL loop_sclk_rises: got %0d want 8", rise_cnt); end
        checks++; if (mosi_log !== 8'hA5) begin failures++; $display("[TB] FAIL loop_mosi_seq: got %b want 10100101", mosi_log); end
        checks++; if (a_rx !== 8'hA5) begin failures++; $display("[TB] FAIL loop_rx: got %h want a5", a_rx); end
        checks++; if (cs_low !== 36) begin failures++; $display("[TB] FAIL loop_cs_low: got %0d want 36", cs_low); end
        checks++; if (busy_high !== 36) begin failures++; $display("[TB] FAIL loop_busy: got %0d want 36", busy_high); end
        checks++; if (a_cs_n !== 1'b1 || a_mosi !== 1'b0) begin failures++; $display("[TB] FAIL loop_fin_pins: cs_n/mosi got %b%b want 10", a_cs_n, a_mosi); end
        repeat (3) @(negedge clk);
        checks++; if (a_rx !== 8'hA5) begin failures++; $display("[TB] FAIL loop_rx_hold: got %h want a5", a_rx); end
    endtask

    task automatic test_slave();
        int done_at, cs_low, busy_high;
        loopback   = 1'b0;
        slave_word = 8'h3C;
        run_a(8'hFF, -10, done_at, cs_low, busy_high);
        checks++; if (a_rx !== 8'h3C) begin failures++; $display("[TB] FAIL slave_rx: got %h want 3c", a_rx); end
        checks++; if (mosi_log !== 8'hFF) begin failures++; $display("[TB] FAIL slave_mosi: got %b want 11111111", mosi_log); end
        checks++; if (done_at !== 37) begin failures++; $display("[TB] FAIL slave_done_cycle: got %0d want 37", done_at); end
        loopback = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int done_at, cs_low, busy_high;
        loopback   = 1'b1;
        a_done_cnt = 0;
        run_a(8'hC3, 10, done_at, cs_low, busy_high);
        repeat (6) @(negedge clk);
        checks++; if (a_done_cnt !== 1) begin failures++; $display("[TB] FAIL ignore_done_count: got %0d want 1", a_done_cnt); end
        checks++; if (a_rx !== 8'hC3) begin failures++; $display("[TB] FAIL ignore_rx: got %h want c3", a_rx); end
        checks++; if (mosi_log !== 8'hC3) begin failures++; $display("[TB] FAIL ignore_mosi: got %b want 11000011", mosi_log); end
        checks++; if (done_at !== 37) begin failures++; $display("[TB] FAIL ignore_done_cycle: got %0d want 37", done_at); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("[TB] FAIL ignore_idle_busy: got %b want 0", a_busy); end
    endtask

    task automatic test_back_to_back();
        int first_done, second_done;
        b_done_cnt  = 0;
        first_done  = -1;
        second_done = -1;
        @(negedge clk);
        b_tx    = 8'h5A;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (b_done) begin
                first_done = i;
                break;
            end
            @(negedge clk);
        end
        checks++; if (first_done !== 19) begin failures++; $display("[TB] FAIL b2b_first_done: got %0d want 19", first_done); end
        checks++; if (b_rx !== 8'h5A) begin failures++; $display("[TB] FAIL b2b_first_rx: got %h want 5a", b_rx); end
        checks++; if (b_cs_n !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done_cs_n: got %b want 1", b_cs_n); end
        // START raised in the DONE cycle and held one more cycle
        b_tx    = 8'h11;
        b_start = 1'b1;
        @(negedge clk);
        checks++; if (b_busy !== 1'b0 || b_cs_n !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done_start_ignored: busy/cs_n got %b%b want 01", b_busy, b_cs_n); end
        @(negedge clk);
        b_start = 1'b0;
        checks++; if (b_busy !== 1'b1 || b_cs_n !== 1'b0) begin failures++; $display("[TB] FAIL b2b_next_accepted: busy/cs_n got %b%b want 10", b_busy, b_cs_n); end
        for (int i = 1; i <= 100; i++) begin
            if (b_done) begin
                second_done = i;
                break;
            end
            @(negedge clk);
        end
        checks++; if (second_done !== 19) begin failures++; $display("[TB] FAIL b2b_second_done: got %0d want 19", second_done); end
        checks++; if (b_rx !== 8'h11) begin failures++; $display("[TB] FAIL b2b_second_rx: got %h want 11", b_rx); end
        repeat (4) @(negedge clk);
        checks++; if (b_done_cnt !== 2) begin failures++; $display("[TB] FAIL b2b_done_count: got %0d want 2", b_done_cnt); end
    endtask

`ifdef SPI_LSB_FIRST_EN
    task automatic test_lsb_first();
        int done_at, cs_low, busy_high;
        loopback = 1'b1;
        a_lsb    = 1'b1;
        run_a(8'h01, -10, done_at, cs_low, busy_high);
        a_lsb = 1'b0;
        checks++; if (mosi_log !== 8'h80) begin failures++; $display("[TB] FAIL lsb_mosi_seq: got %b want 10000000", mosi_log); end
        checks++; if (rise_cnt !== 8) begin failures++; $display("[TB] FAIL lsb_sclk_rises: got %0d want 8", rise_cnt); end
        checks++; if (a_rx !== 8'h01) begin failures++; $display("[TB] FAIL lsb_rx: got %h want 01", a_rx); end
        checks++; if (done_at !== 37) begin failures++; $display("[TB] FAIL lsb_done_cycle: got %0d want 37", done_at); end
    endtask
`endif

    // Scenario sequence
    initial begin
        checks     = 0;
        failures   = 0;
        a_done_cnt = 0;
        b_done_cnt = 0;
        rise_cnt   = 0;
        mosi_log   = '0;
        loopback   = 1'b1;
        slave_word = 8'h00;
        slave_bit  = 1'b0;
        slave_idx  = 0;
        a_start    = 1'b0;
        b_start    = 1'b0;
        a_tx       = 8'h00;
        b_tx       = 8'h00;
`ifdef SPI_LSB_FIRST_EN
        a_lsb      = 1'b0;
        b_lsb      = 1'b0;
`endif
        clr_n      = 1'b1;
        #2 clr_n   = 1'b0;

        test_reset();
        test_loopback();
        test_slave();
        test_start_ignored();
        test_back_to_back();
`ifdef SPI_LSB_FIRST_EN
        test_lsb_first();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
